// File: rtl/asp_hazard_pkg.sv
// Shared state encoding and default widths for the ASP hazard/stall controller.
package asp_hazard_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_PERF_W     = 16;
  localparam int DEF_MULDIV_LAT = 4;
  localparam int DEF_CNT_W      = 3;
endpackage

// File: rtl/muldiv_latency_counter.sv
// Tracks EX occupancy of a multicycle mul/div op: IDLE -> BUSY (MULDIV_LAT cycles) -> DONE pulse.
module muldiv_latency_counter import asp_hazard_pkg::*; #(
  parameter int MULDIV_LAT = DEF_MULDIV_LAT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic   CLK,
  input  logic   Reset,
  input  logic   MulDiv_Start,
  output state_t State,
  output logic   MulDiv_Busy,
  output logic   MulDiv_Done
);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MULDIV_LAT - 1);

  logic [CNT_W-1:0] countReg;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      State       <= IDLE;
      countReg    <= '0;
      MulDiv_Busy <= 1'b0;
      MulDiv_Done <= 1'b0;
    end else begin
      case (State)
        IDLE: begin
          MulDiv_Done <= 1'b0;
          if (MulDiv_Start) begin
            State       <= BUSY;
            countReg    <= RELOAD;
            MulDiv_Busy <= 1'b1;
          end
        end
        BUSY: begin
          // A new start request cannot be accepted while EX is occupied.
          if (countReg == '0) begin
            State       <= DONE;
            MulDiv_Busy <= 1'b0;
            MulDiv_Done <= 1'b1;
          end else begin
            countReg <= countReg - CNT_W'(1);
          end
        end
        DONE: begin
          MulDiv_Done <= 1'b0;
          if (MulDiv_Start) begin
            State       <= BUSY;
            countReg    <= RELOAD;
            MulDiv_Busy <= 1'b1;
          end else begin
            State <= IDLE;
          end
        end
        default: begin
          State       <= IDLE;
          MulDiv_Busy <= 1'b0;
          MulDiv_Done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: load-use detect, mul/div EX freeze, branch flush and stall-cycle counter.
module hazard_stall_unit import asp_hazard_pkg::*; #(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int MULDIV_LAT = DEF_MULDIV_LAT,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int PERF_W     = DEF_PERF_W
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  IdEx_MemRead,
  input  logic [REG_ADDR_W-1:0] IdEx_Rd,
  input  logic [REG_ADDR_W-1:0] IfId_Rs,
  input  logic [REG_ADDR_W-1:0] IfId_Rt,
  input  logic                  IfId_UsesRt,
  input  logic                  Branch_Taken,
  input  logic                  MulDiv_Start,
  output logic                  Stall_PC,
  output logic                  Stall_IfId,
  output logic                  Stall_IdEx,
  output logic                  Bubble_IdEx,
  output logic                  Flush_IfId,
  output logic                  MulDiv_Busy,
  output logic                  MulDiv_Done,
  output logic [PERF_W-1:0]     StallCycles
);
  state_t mdState;
  logic   loadUse;

  muldiv_latency_counter #(
    .MULDIV_LAT (MULDIV_LAT),
    .CNT_W      (CNT_W)
  ) uMulDiv (
    .CLK          (CLK),
    .Reset        (Reset),
    .MulDiv_Start (MulDiv_Start),
    .State        (mdState),
    .MulDiv_Busy  (MulDiv_Busy),
    .MulDiv_Done  (MulDiv_Done)
  );

  // x0 is hardwired zero, so a load targeting it never produces a hazard.
  assign loadUse = IdEx_MemRead && (IdEx_Rd != '0) &&
                   ((IdEx_Rd == IfId_Rs) || (IfId_UsesRt && (IdEx_Rd == IfId_Rt)));

  always_comb begin
    Stall_PC    = 1'b0;
    Stall_IfId  = 1'b0;
    Stall_IdEx  = 1'b0;
    Bubble_IdEx = 1'b0;
    Flush_IfId  = 1'b0;
    if (Reset) begin
      if (mdState == BUSY) begin
        Stall_PC   = 1'b1;
        Stall_IfId = 1'b1;
        Stall_IdEx = 1'b1;
      end else if (Branch_Taken) begin
        Flush_IfId  = 1'b1;
        Bubble_IdEx = 1'b1;
      end else if (loadUse) begin
        Stall_PC    = 1'b1;
        Stall_IfId  = 1'b1;
        Bubble_IdEx = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      StallCycles <= '0;
    end else if (Stall_PC && (StallCycles != '1)) begin
      StallCycles <= StallCycles + PERF_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: load-use/branch vector table plus mul/div, reset and saturation sequences.
module tb_hazard_stall_unit;
  logic        CLK = 1'b0;
  logic        Reset;
  logic        IdEx_MemRead;
  logic [4:0]  IdEx_Rd;
  logic [4:0]  IfId_Rs;
  logic [4:0]  IfId_Rt;
  logic        IfId_UsesRt;
  logic        Branch_Taken;
  logic        MulDiv_Start;
  logic        Stall_PC;
  logic        Stall_IfId;
  logic        Stall_IdEx;
  logic        Bubble_IdEx;
  logic        Flush_IfId;
  logic        MulDiv_Busy;
  logic        MulDiv_Done;
  logic [15:0] StallCycles;

  int checks = 0;
  int errors = 0;
  int expStall = 0;

  typedef struct packed {
    logic       memRead;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRt;
    logic       branch;
    logic       expStallPc;
    logic       expStallIfId;
    logic       expBubble;
    logic       expFlush;
  } vec_t;

  vec_t vecs [10];

  hazard_stall_unit #(
    .REG_ADDR_W (5),
    .MULDIV_LAT (4),
    .CNT_W      (3),
    .PERF_W     (16)
  ) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .IdEx_MemRead (IdEx_MemRead),
    .IdEx_Rd      (IdEx_Rd),
    .IfId_Rs      (IfId_Rs),
    .IfId_Rt      (IfId_Rt),
    .IfId_UsesRt  (IfId_UsesRt),
    .Branch_Taken (Branch_Taken),
    .MulDiv_Start (MulDiv_Start),
    .Stall_PC     (Stall_PC),
    .Stall_IfId   (Stall_IfId),
    .Stall_IdEx   (Stall_IdEx),
    .Bubble_IdEx  (Bubble_IdEx),
    .Flush_IfId   (Flush_IfId),
    .MulDiv_Busy  (MulDiv_Busy),
    .MulDiv_Done  (MulDiv_Done),
    .StallCycles  (StallCycles)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkCtl(input string tag, input logic pc, input logic ifid, input logic idex,
                        input logic bub, input logic fl);
    chk({tag, ".Stall_PC"},    {31'd0, Stall_PC},    {31'd0, pc});
    chk({tag, ".Stall_IfId"},  {31'd0, Stall_IfId},  {31'd0, ifid});
    chk({tag, ".Stall_IdEx"},  {31'd0, Stall_IdEx},  {31'd0, idex});
    chk({tag, ".Bubble_IdEx"}, {31'd0, Bubble_IdEx}, {31'd0, bub});
    chk({tag, ".Flush_IfId"},  {31'd0, Flush_IfId},  {31'd0, fl});
  endtask

  task automatic clearIn();
    IdEx_MemRead = 1'b0;
    IdEx_Rd      = 5'd0;
    IfId_Rs      = 5'd0;
    IfId_Rt      = 5'd0;
    IfId_UsesRt  = 1'b0;
    Branch_Taken = 1'b0;
    MulDiv_Start = 1'b0;
  endtask

  initial begin
    //          MR    Rd     Rs     Rt     URt  Br    PC   IfId Bub  Fl
    vecs[0] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 5'd5,  5'd3,  5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 5'd5,  5'd3,  5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 5'd5,  5'd5,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 5'd9,  5'd1,  5'd2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 5'd0,  5'd3,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 5'd7,  5'd5,  5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 5'd31, 5'd4,  5'd31, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    clearIn();
    Reset = 1'b0;
    #1;
    chkCtl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.Busy", {31'd0, MulDiv_Busy}, 32'd0);
    chk("reset.Done", {31'd0, MulDiv_Done}, 32'd0);
    chk("reset.StallCycles", {16'd0, StallCycles}, 32'd0);
    repeat (2) @(negedge CLK);
    Reset = 1'b1;

    // Single mul/div op; Branch_Taken, LU and a second Start arrive while BUSY and must be ignored.
    @(negedge CLK);
    MulDiv_Start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      MulDiv_Start = (i == 2);
      Branch_Taken = (i == 1);
      IdEx_MemRead = (i == 1);
      IdEx_Rd      = 5'd5;
      IfId_Rs      = 5'd5;
      #1;
      $display("muldiv busy cycle %0d: StallIdEx=%0b Busy=%0b Flush=%0b", i, Stall_IdEx, MulDiv_Busy, Flush_IfId);
      chkCtl($sformatf("busy%0d", i), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("busy%0d.Busy", i), {31'd0, MulDiv_Busy}, 32'd1);
      chk($sformatf("busy%0d.Done", i), {31'd0, MulDiv_Done}, 32'd0);
    end
    @(negedge CLK);
    clearIn();
    #1;
    expStall = 4;
    $display("muldiv done: Done=%0b StallCycles=%0d", MulDiv_Done, StallCycles);
    chk("done.Done", {31'd0, MulDiv_Done}, 32'd1);
    chk("done.Busy", {31'd0, MulDiv_Busy}, 32'd0);
    chk("done.StallIdEx", {31'd0, Stall_IdEx}, 32'd0);
    chk("done.StallCycles", {16'd0, StallCycles}, expStall);
    @(negedge CLK);
    #1;
    chk("idle.Done", {31'd0, MulDiv_Done}, 32'd0);

    // Back-to-back: Start asserted during the DONE cycle re-enters BUSY directly.
    MulDiv_Start = 1'b1;
    @(negedge CLK);
    MulDiv_Start = 1'b0;
    repeat (4) @(negedge CLK);
    #1;
    chk("b2b.Done1", {31'd0, MulDiv_Done}, 32'd1);
    MulDiv_Start = 1'b1;
    @(negedge CLK);
    MulDiv_Start = 1'b0;
    #1;
    chk("b2b.Busy", {31'd0, MulDiv_Busy}, 32'd1);
    chk("b2b.Done1Pulse", {31'd0, MulDiv_Done}, 32'd0);
    repeat (4) @(negedge CLK);
    #1;
    expStall += 8;
    $display("b2b done: Done=%0b StallCycles=%0d", MulDiv_Done, StallCycles);
    chk("b2b.Done2", {31'd0, MulDiv_Done}, 32'd1);
    chk("b2b.StallCycles", {16'd0, StallCycles}, expStall);
    @(negedge CLK);

    // Load-use / branch vector table.
    for (int i = 0; i < 10; i++) begin
      IdEx_MemRead = vecs[i].memRead;
      IdEx_Rd      = vecs[i].rd;
      IfId_Rs      = vecs[i].rs;
      IfId_Rt      = vecs[i].rt;
      IfId_UsesRt  = vecs[i].usesRt;
      Branch_Taken = vecs[i].branch;
      #1;
      $display("vec %0d: PC=%0b IfId=%0b Bub=%0b Fl=%0b", i, Stall_PC, Stall_IfId, Bubble_IdEx, Flush_IfId);
      chkCtl($sformatf("vec%0d", i), vecs[i].expStallPc, vecs[i].expStallIfId, 1'b0,
             vecs[i].expBubble, vecs[i].expFlush);
      expStall += int'(vecs[i].expStallPc);
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d.StallCycles", i), {16'd0, StallCycles}, expStall);
      @(negedge CLK);
    end
    clearIn();

    // Asynchronous reset mid-BUSY (counter=2) with hazard inputs active.
    MulDiv_Start = 1'b1;
    @(negedge CLK);
    MulDiv_Start = 1'b0;
    @(negedge CLK);
    IdEx_MemRead = 1'b1;
    IdEx_Rd      = 5'd5;
    IfId_Rs      = 5'd5;
    Branch_Taken = 1'b1;
    #2;
    Reset = 1'b0;
    #1;
    $display("async reset: Busy=%0b PC=%0b StallCycles=%0d", MulDiv_Busy, Stall_PC, StallCycles);
    chkCtl("rstBusy", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rstBusy.Busy", {31'd0, MulDiv_Busy}, 32'd0);
    chk("rstBusy.StallCycles", {16'd0, StallCycles}, 32'd0);
    @(negedge CLK);
    clearIn();
    @(negedge CLK);
    Reset = 1'b1;
    expStall = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      #1;
      chk($sformatf("postRst%0d.Busy", i), {31'd0, MulDiv_Busy}, 32'd0);
      chk($sformatf("postRst%0d.Done", i), {31'd0, MulDiv_Done}, 32'd0);
    end
    chk("postRst.StallCycles", {16'd0, StallCycles}, 32'd0);

    // Saturation: hold LU until the counter reaches 0xFFFE, then three more stall cycles.
    IdEx_MemRead = 1'b1;
    IdEx_Rd      = 5'd5;
    IfId_Rs      = 5'd5;
    repeat (65534) @(negedge CLK);
    #1;
    $display("sat preload: StallCycles=0x%0h", StallCycles);
    chk("sat.Preload", {16'd0, StallCycles}, 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1;
      $display("sat cycle %0d: StallCycles=0x%0h StallPC=%0b", i, StallCycles, Stall_PC);
      chk($sformatf("sat%0d.StallCycles", i), {16'd0, StallCycles}, 32'h0000_FFFF);
      chk($sformatf("sat%0d.Stall_PC", i), {31'd0, Stall_PC}, 32'd1);
    end
    clearIn();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
